// File: rtl/ffq_round_ctrl.sv
// Quiz-master round controller: arms the buzzer, decodes its 7-segment output
// into a winning player, times the answer window and keeps per-player scores.
module ffq_round_ctrl #(
    parameter int ANS_CYCLES = 50,
    parameter int SCORE_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 judge_ok,
    input  logic                 judge_bad,
    input  logic [6:0]           seg_in,
    output logic                 en,
    output logic [2:0]           winner,
    output logic                 busy,
    output logic [4*SCORE_W-1:0] scores,
    output logic [7:0]           round_cnt,
    output logic                 timeout,
    output logic                 seg_err
);

    typedef enum logic [1:0] {IDLE, ARM, ANSWER} state_t;
    typedef enum logic [1:0] {SEG_BLANK, SEG_PLAYER, SEG_ILLEGAL} seg_kind_t;

    localparam logic [15:0]        TIMER_LOAD = 16'(ANS_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    // ------------------------------------------------------------------
    // Input conditioning: 2-flop synchronizer plus a compare stage
    // ------------------------------------------------------------------
    logic [6:0] s1, s2, s3;
    logic       stable;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchronizer chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= seg_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign stable = (s2 == s3);

    // ------------------------------------------------------------------
    // Segment decode of the filtered pattern
    // ------------------------------------------------------------------
    seg_kind_t  seg_kind;
    logic [2:0] seg_player;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a value unassigned and infer a latch.
    always_comb begin
        seg_kind   = SEG_ILLEGAL;
        seg_player = 3'd0;
        case (s3)
            7'b0000000: seg_kind = SEG_BLANK;
            7'b0000110: begin seg_kind = SEG_PLAYER; seg_player = 3'd1; end
            7'b1011011: begin seg_kind = SEG_PLAYER; seg_player = 3'd2; end
            7'b1001111: begin seg_kind = SEG_PLAYER; seg_player = 3'd3; end
            7'b1100110: begin seg_kind = SEG_PLAYER; seg_player = 3'd4; end
            default:    seg_kind = SEG_ILLEGAL;
        endcase
    end

    // ------------------------------------------------------------------
    // Round FSM
    // ------------------------------------------------------------------
    state_t      state, state_nxt;
    logic [15:0] timer, timer_nxt;
    logic        clear_winner, load_winner, score_inc, round_done;
    logic        timeout_nxt, seg_err_nxt;
    logic        err_hit, err_prev;
    logic [6:0]  err_pat;

    // An illegal pattern held steady reports once, not on every cycle it stays.
    assign err_hit = (state == ARM) && stable && (seg_kind == SEG_ILLEGAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        clear_winner = 1'b0;
        load_winner  = 1'b0;
        score_inc    = 1'b0;
        round_done   = 1'b0;
        timeout_nxt  = 1'b0;
        seg_err_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = ARM;
                    clear_winner = 1'b1;
                end
            end
            ARM: begin
                if (stable && seg_kind == SEG_PLAYER) begin
                    load_winner = 1'b1;
                    timer_nxt   = TIMER_LOAD;
                    state_nxt   = ANSWER;
                end else if (err_hit && !(err_prev && err_pat == s3)) begin
                    seg_err_nxt = 1'b1;
                end
            end
            ANSWER: begin
                timer_nxt = timer - 16'd1;
                if (judge_bad) begin
                    state_nxt = IDLE;
                end else if (judge_ok) begin
                    score_inc = 1'b1;
                    state_nxt = IDLE;
                end else if (timer == 16'd0) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end
                if (state_nxt == IDLE) begin
                    round_done = 1'b1;
                    timer_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and datapath
    // ------------------------------------------------------------------
    logic [SCORE_W-1:0] score_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en        <= 1'b1;
            busy      <= 1'b0;
            winner    <= 3'd0;
            timer     <= '0;
            timeout   <= 1'b0;
            seg_err   <= 1'b0;
            err_prev  <= 1'b0;
            err_pat   <= '0;
            round_cnt <= 8'd0;
        end else begin
            en       <= (state_nxt == IDLE);
            busy     <= (state_nxt != IDLE);
            timer    <= timer_nxt;
            timeout  <= timeout_nxt;
            seg_err  <= seg_err_nxt;
            err_prev <= err_hit;
            err_pat  <= s3;
            if (clear_winner) begin
                winner <= 3'd0;
            end else if (load_winner) begin
                winner <= seg_player;
            end
            if (round_done) begin
                round_cnt <= round_cnt + 8'd1;
            end
        end
    end

    // NOTE: the score bank is four small registers, not a RAM, so it is reset
    // with the rest of the state; a mid-round reset must clear the scores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 4; p++) begin
                score_q[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (score_inc && winner == 3'(p + 1) && score_q[p] != SCORE_MAX) begin
                    score_q[p] <= score_q[p] + SCORE_W'(1);
                end
            end
        end
    end

    always_comb begin
        scores = '0;
        for (int p = 0; p < 4; p++) begin
            scores[p*SCORE_W +: SCORE_W] = score_q[p];
        end
    end

endmodule

// File: tb/tb_ffq_round_ctrl.sv
// Bench for ffq_round_ctrl: a round-level reference model checked every cycle,
// plus literal expectations at key points of each directed scenario.
module tb_ffq_round_ctrl;

    localparam int ANS = 5;
    localparam int SW  = 2;
    localparam logic [6:0] P1    = 7'b0000110;
    localparam logic [6:0] P2    = 7'b1011011;
    localparam logic [6:0] P3    = 7'b1001111;
    localparam logic [6:0] P4    = 7'b1100110;
    localparam logic [6:0] BLANK = 7'b0000000;
    localparam logic [6:0] BAD   = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start, judge_ok, judge_bad;
    logic [6:0]    seg_in;
    logic          en, busy, timeout, seg_err;
    logic [2:0]    winner;
    logic [4*SW-1:0] scores;
    logic [7:0]    round_cnt;

    logic          b_start, b_ok, b_bad;
    logic [6:0]    b_seg;
    logic          b_en, b_busy, b_timeout, b_seg_err;
    logic [2:0]    b_winner;
    logic [15:0]   b_scores;
    logic [7:0]    b_round;

    int checks = 0;
    int errors = 0;

    ffq_round_ctrl #(.ANS_CYCLES(ANS), .SCORE_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .judge_ok(judge_ok),
        .judge_bad(judge_bad), .seg_in(seg_in), .en(en), .winner(winner),
        .busy(busy), .scores(scores), .round_cnt(round_cnt),
        .timeout(timeout), .seg_err(seg_err)
    );

    ffq_round_ctrl #(.ANS_CYCLES(1), .SCORE_W(4)) dut_one (
        .clk(clk), .rst_n(rst_n), .start(b_start), .judge_ok(b_ok),
        .judge_bad(b_bad), .seg_in(b_seg), .en(b_en), .winner(b_winner),
        .busy(b_busy), .scores(b_scores), .round_cnt(b_round),
        .timeout(b_timeout), .seg_err(b_seg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Round-level reference model
    // ------------------------------------------------------------------
    typedef enum int {M_IDLE, M_ARM, M_ANSWER} mphase_t;
    mphase_t    m_phase;
    int         m_left, m_winner, m_rounds, m_code;
    int         m_score [1:4];
    bit         m_timeout, m_seg_err, m_acc, m_err_now, m_err_prev;
    logic [6:0] m_samp [3];
    logic [6:0] m_err_pat;

    function automatic int seg_to_player(input logic [6:0] p);
        case (p)
            P1:      return 1;
            P2:      return 2;
            P3:      return 3;
            P4:      return 4;
            BLANK:   return 0;
            default: return -1;
        endcase
    endfunction

    function automatic logic [4*SW-1:0] pack_scores();
        logic [4*SW-1:0] v = '0;
        for (int p = 1; p <= 4; p++) v[p*SW-1 -: SW] = SW'(m_score[p]);
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = M_IDLE; m_left = 0; m_winner = 0; m_rounds = 0;
            for (int p = 1; p <= 4; p++) m_score[p] = 0;
            m_timeout = 0; m_seg_err = 0; m_err_prev = 0; m_err_pat = '0;
            for (int i = 0; i < 3; i++) m_samp[i] = '0;
        end else begin
            // m_samp[0..2] mirror the last three samples of seg_in, newest first
            m_acc     = (m_samp[1] == m_samp[2]);
            m_code    = seg_to_player(m_samp[2]);
            m_err_now = (m_phase == M_ARM) && m_acc && (m_code < 0);
            m_timeout = 0;
            m_seg_err = 0;
            case (m_phase)
                M_IDLE: if (start) begin m_phase = M_ARM; m_winner = 0; end
                M_ARM: begin
                    if (m_acc && m_code > 0) begin
                        m_winner = m_code; m_left = ANS; m_phase = M_ANSWER;
                    end else if (m_err_now && !(m_err_prev && m_err_pat == m_samp[2])) begin
                        m_seg_err = 1;
                    end
                end
                default: begin
                    if (judge_bad || judge_ok || m_left == 1) begin
                        if (!judge_bad && judge_ok) begin
                            if (m_score[m_winner] < (1 << SW) - 1) m_score[m_winner]++;
                        end else if (!judge_bad) begin
                            m_timeout = 1;
                        end
                        m_rounds = (m_rounds + 1) % 256;
                        m_phase  = M_IDLE;
                    end else begin
                        m_left--;
                    end
                end
            endcase
            m_err_prev = m_err_now;
            m_err_pat  = m_samp[2];
            m_samp[2]  = m_samp[1];
            m_samp[1]  = m_samp[0];
            m_samp[0]  = seg_in;
        end
    end

    bit cmp_on = 1'b0;

    always @(negedge clk) begin
        if (cmp_on && rst_n) begin
            check("cmp_en",      32'(en),        32'(m_phase == M_IDLE));
            check("cmp_busy",    32'(busy),      32'(m_phase != M_IDLE));
            check("cmp_winner",  32'(winner),    32'(m_winner));
            check("cmp_scores",  32'(scores),    32'(pack_scores()));
            check("cmp_rounds",  32'(round_cnt), 32'(m_rounds));
            check("cmp_timeout", 32'(timeout),   32'(m_timeout));
            check("cmp_seg_err", 32'(seg_err),   32'(m_seg_err));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench did not finish");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    int err_cnt;
    int exp_s1 [5] = '{1, 2, 3, 3, 3};

    initial begin
        start = 0; judge_ok = 0; judge_bad = 0; seg_in = BLANK;
        b_start = 0; b_ok = 0; b_bad = 0; b_seg = BLANK;
        #12;
        check("rst_en",      32'(en),        32'd1);
        check("rst_busy",    32'(busy),      32'd0);
        check("rst_winner",  32'(winner),    32'd0);
        check("rst_scores",  32'(scores),    32'd0);
        check("rst_rounds",  32'(round_cnt), 32'd0);
        check("rst_timeout", 32'(timeout),   32'd0);
        check("rst_seg_err", 32'(seg_err),   32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_on = 1'b1;

        // Basic round: player 2 wins and is judged correct
        start = 1; cyc(1); start = 0;
        check("t1_en_armed", 32'(en), 32'd0);
        seg_in = P2; cyc(3);
        check("t1_latency_winner", 32'(winner), 32'd0);
        cyc(1);
        check("t1_winner", 32'(winner), 32'd2);
        check("t1_busy",   32'(busy),   32'd1);
        judge_ok = 1; cyc(1); judge_ok = 0; seg_in = BLANK;
        check("t1_scores", 32'(scores),    32'h04);
        check("t1_rounds", 32'(round_cnt), 32'd1);
        check("t1_en",     32'(en),        32'd1);
        judge_ok = 1; cyc(1); judge_ok = 0;
        check("t1_idle_judge", 32'(scores), 32'h04);

        // Timeout: player 4, no judge; stray judge in ARM and start in ARM/ANSWER
        cyc(3);
        start = 1; cyc(1); start = 0;
        seg_in = P4; judge_ok = 1; cyc(1);
        judge_ok = 0; start = 1; cyc(1);
        start = 0; cyc(2);
        check("t2_winner", 32'(winner), 32'd4);
        start = 1; cyc(1); start = 0; cyc(3);
        check("t2_last_cycle_busy", 32'(busy),    32'd1);
        check("t2_no_early_timeout", 32'(timeout), 32'd0);
        cyc(1);
        check("t2_timeout", 32'(timeout),   32'd1);
        check("t2_rounds",  32'(round_cnt), 32'd2);
        check("t2_scores",  32'(scores),    32'h04);
        cyc(1);
        check("t2_timeout_width", 32'(timeout), 32'd0);
        check("t2_start_ignored", 32'(busy),    32'd0);
        seg_in = BLANK;

        // Glitch filter, then a stable illegal pattern, then a real press
        cyc(3);
        start = 1; cyc(1); start = 0; cyc(2);
        seg_in = P1; cyc(1); seg_in = BLANK;
        err_cnt = 0;
        for (int i = 0; i < 6; i++) begin cyc(1); err_cnt += int'(seg_err); end
        check("t3_glitch_winner", 32'(winner),  32'd0);
        check("t3_glitch_err",    32'(err_cnt), 32'd0);
        check("t3_glitch_busy",   32'(busy),    32'd1);
        seg_in = BAD;
        err_cnt = 0;
        for (int i = 0; i < 8; i++) begin cyc(1); err_cnt += int'(seg_err); end
        check("t3_illegal_pulses", 32'(err_cnt), 32'd1);
        check("t3_illegal_busy",   32'(busy),    32'd1);
        seg_in = P1; cyc(4);
        check("t3_winner", 32'(winner), 32'd1);
        judge_ok = 1; judge_bad = 1; cyc(1); judge_ok = 0; judge_bad = 0;
        seg_in = BLANK;
        check("t3_both_scores", 32'(scores),    32'h04);
        check("t3_both_rounds", 32'(round_cnt), 32'd3);
        check("t3_both_idle",   32'(busy),      32'd0);

        // Judge in the cycle where the timer reaches zero
        cyc(3);
        start = 1; cyc(1); start = 0;
        seg_in = P3; cyc(4); cyc(4);
        check("t4_still_answer", 32'(busy), 32'd1);
        judge_bad = 1; cyc(1); judge_bad = 0; seg_in = BLANK;
        check("t4_no_timeout", 32'(timeout),   32'd0);
        check("t4_rounds",     32'(round_cnt), 32'd4);
        cyc(1);
        check("t4_no_timeout_late", 32'(timeout), 32'd0);

        // Saturation with a 2-bit score
        for (int r = 0; r < 5; r++) begin
            cyc(3);
            start = 1; cyc(1); start = 0;
            seg_in = P1; cyc(4);
            judge_ok = 1; cyc(1); judge_ok = 0; seg_in = BLANK;
            check("t5_score1", 32'(scores[SW-1:0]), 32'(exp_s1[r]));
        end
        check("t5_scores", 32'(scores),    32'h07);
        check("t5_rounds", 32'(round_cnt), 32'd9);

        // Asynchronous reset in the middle of ANSWER
        cyc(3);
        start = 1; cyc(1); start = 0;
        seg_in = P3; cyc(4);
        check("t6_winner", 32'(winner), 32'd3);
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_en",      32'(en),        32'd1);
        check("t6_winner0", 32'(winner),    32'd0);
        check("t6_busy",    32'(busy),      32'd0);
        check("t6_scores",  32'(scores),    32'd0);
        check("t6_rounds",  32'(round_cnt), 32'd0);
        check("t6_timeout", 32'(timeout),   32'd0);
        check("t6_seg_err", 32'(seg_err),   32'd0);
        seg_in = BLANK;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);
        start = 1; cyc(1); start = 0;
        seg_in = P4; cyc(4);
        check("t6_after_winner", 32'(winner), 32'd4);
        judge_ok = 1; cyc(1); judge_ok = 0; seg_in = BLANK;
        check("t6_after_scores", 32'(scores),    32'h40);
        check("t6_after_rounds", 32'(round_cnt), 32'd1);

        // One-cycle answer window
        cyc(3);
        b_start = 1; cyc(1); b_start = 0;
        b_seg = P1; cyc(4);
        check("t7_winner",  32'(b_winner),  32'd1);
        check("t7_busy",    32'(b_busy),    32'd1);
        check("t7_pre",     32'(b_timeout), 32'd0);
        cyc(1);
        check("t7_timeout", 32'(b_timeout), 32'd1);
        check("t7_idle",    32'(b_busy),    32'd0);
        check("t7_rounds",  32'(b_round),   32'd1);
        b_seg = BLANK; cyc(4);
        b_start = 1; cyc(1); b_start = 0;
        b_seg = P2; cyc(4);
        check("t7_winner2", 32'(b_winner), 32'd2);
        b_ok = 1; cyc(1); b_ok = 0; b_seg = BLANK;
        check("t7_judged_no_timeout", 32'(b_timeout), 32'd0);
        check("t7_scores",  32'(b_scores), 32'h0010);
        check("t7_rounds2", 32'(b_round),  32'd2);
        cyc(1);
        check("t7_no_late_timeout", 32'(b_timeout), 32'd0);

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
